// File: rtl/spi_master_pkg.sv
// Shared SPI master definitions: FSM state encoding, SPI mode constants and a clog2 helper.
package spi_master_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StSckHi,
    StSckLo,
    StGap
  } spi_state_e;

  // Mode 0: sclk idles low, data sampled on the leading (rising) edge.
  localparam logic Cpol = 1'b0;
  localparam logic Cpha = 1'b0;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned res;
    res = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) res = i + 1;
    end
    return res;
  endfunction

endpackage

// File: rtl/spi_master_if.sv
// Controller-side handshake plus SPI pins of the SPI master.
interface spi_master_if #(
  parameter int unsigned word_size = 8
);
  logic                 start;
  logic [word_size-1:0] data_2_send;
  logic [word_size-1:0] data_rcv;
  logic                 done;
  logic                 busy;
  logic                 sclk;
  logic                 cs;
  logic                 mosi;
  logic                 miso;

  modport master (
    input  start, data_2_send, miso,
    output data_rcv, done, busy, sclk, cs, mosi
  );

  modport slave (
    output start, data_2_send, miso,
    input  data_rcv, done, busy, sclk, cs, mosi
  );
endinterface

// File: rtl/spi_master_clk_gen.sv
// Half-period timer: ticks on the last cycle of every CLK_DIV-cycle window while enabled.
module spi_master_clk_gen
  import spi_master_pkg::*;
#(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic restart,
  output logic tick
);
  localparam int unsigned CntW = clog2(CLK_DIV) + 1;
  localparam logic [CntW-1:0] CntLast = CntW'(CLK_DIV - 1);

  logic [CntW-1:0] cnt_q;

  always_comb begin
    tick = en && (cnt_q == CntLast);
  end

  always_ff @(posedge clk) begin
    if (rst || restart) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= tick ? '0 : cnt_q + CntW'(1);
    end
  end
endmodule

// File: rtl/spi_master.sv
// SPI mode-0 master: shifts one MSB-first word out on mosi while capturing miso.
module spi_master
  import spi_master_pkg::*;
#(
  parameter int unsigned word_size = 8,
  parameter int unsigned CLK_DIV   = 2
) (
  input  logic          clk,
  input  logic          rst,
  spi_master_if.master  bus
);
  localparam int unsigned BitCntW = clog2(word_size) + 1;
  localparam logic [BitCntW-1:0] WordCnt = BitCntW'(word_size);

  spi_state_e           state_q;
  logic [word_size-1:0] tx_q;
  logic [word_size-1:0] rx_q;
  logic [word_size-1:0] data_rcv_q;
  logic [BitCntW-1:0]   bit_cnt_q;
  logic                 sclk_q;
  logic                 cs_q;
  logic                 busy_q;
  logic                 done_q;
  logic                 tick;

  spi_master_clk_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_clk_gen (
    .clk     (clk),
    .rst     (rst),
    .en      (state_q != StIdle),
    .restart (state_q == StIdle),
    .tick    (tick)
  );

  // mosi is the tx MSB; clearing tx on return to idle parks mosi low.
  assign bus.mosi     = tx_q[word_size-1];
  assign bus.sclk     = sclk_q;
  assign bus.cs       = cs_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.data_rcv = data_rcv_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      tx_q       <= '0;
      rx_q       <= '0;
      data_rcv_q <= '0;
      bit_cnt_q  <= '0;
      sclk_q     <= Cpol;
      cs_q       <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bus.start) begin
            tx_q      <= bus.data_2_send;
            bit_cnt_q <= '0;
            cs_q      <= 1'b0;
            busy_q    <= 1'b1;
            state_q   <= StSetup;
          end
        end
        StSetup: begin
          if (tick) begin
            sclk_q    <= ~Cpol;
            rx_q      <= {rx_q[word_size-2:0], bus.miso};
            bit_cnt_q <= bit_cnt_q + BitCntW'(1);
            state_q   <= StSckHi;
          end
        end
        StSckHi: begin
          if (tick) begin
            sclk_q  <= Cpol;
            state_q <= StSckLo;
            // After the last bit mosi keeps its value until the frame ends.
            if (bit_cnt_q < WordCnt) tx_q <= {tx_q[word_size-2:0], 1'b0};
          end
        end
        StSckLo: begin
          if (tick) begin
            if (bit_cnt_q < WordCnt) begin
              sclk_q    <= ~Cpol;
              rx_q      <= {rx_q[word_size-2:0], bus.miso};
              bit_cnt_q <= bit_cnt_q + BitCntW'(1);
              state_q   <= StSckHi;
            end else begin
              cs_q       <= 1'b1;
              done_q     <= 1'b1;
              data_rcv_q <= rx_q;
              state_q    <= StGap;
            end
          end
        end
        StGap: begin
          if (tick) begin
            busy_q  <= 1'b0;
            tx_q    <= '0;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end
endmodule

// File: doc/spi_master.md
Name: spi_master

Overview:
SPI master (initiator) that serialises one word onto mosi while capturing one word from miso. It drives sclk and an active-low cs from the system clock. Timing is SPI mode 0, MSB first: data changes on sclk falling edge and is sampled on sclk rising edge. It is the counterpart to the team's SPI slave and sits between a local controller (start/done handshake) and the off-chip or on-chip SPI slave.

Parameters:
word_size, 8, bits per transfer (>=2)
CLK_DIV, 2, clk cycles per sclk half-period (>=1)

Ports:
clk  input  1  system clock, all logic on posedge
rst  input  1  synchronous, active-high reset
start  input  1  request transfer; sampled only when busy=0
data_2_send  input  word_size  word to transmit; latched on accepted start
data_rcv  output  word_size  last received word; updated only with done
done  output  1  one-cycle pulse at end of transfer
busy  output  1  high from cycle after accepted start until end of GAP
sclk  output  1  SPI clock, idles low
cs  output  1  active-low chip select, idles high
mosi  output  1  serial data out, MSB first
miso  input  1  serial data in

Behaviour:
- Reset (rst=1 at posedge): state IDLE, cs=1, sclk=0, mosi=0, busy=0, done=0, data_rcv=0, counters and shift registers cleared. Reset mid-transfer aborts immediately; no done pulse; cs high next cycle.
- States: IDLE -> SETUP -> SCK_HI <-> SCK_LO -> GAP -> IDLE.
- IDLE: if start=1, latch data_2_send into tx shift register, clear bit counter. Next cycle: cs=0, mosi=data_2_send[word_size-1], busy=1, enter SETUP. start while busy=1 is ignored (not queued).
- SETUP: hold for CLK_DIV cycles with sclk=0, then sclk=1 and enter SCK_HI.
- SCK_HI: on entry (sclk rising edge), shift miso into rx register LSB, increment bit counter. Hold CLK_DIV cycles, then sclk=0.
- SCK_LO: if bit counter < word_size, drive next tx bit on mosi at the falling edge, hold CLK_DIV cycles, then return to SCK_HI. If bit counter = word_size, hold CLK_DIV cycles; in the final cycle of this phase, set cs=1, pulse done=1, load data_rcv from rx register, then enter GAP.
- GAP: cs=1, sclk=0, busy=1 for CLK_DIV cycles, guaranteeing a minimum cs-high time. Then busy=0 and enter IDLE.
- Timing, with accepted start at cycle 0: cs falls at cycle 1; exactly word_size sclk rising edges occur; done occurs at cycle 1+CLK_DIV+2*word_size*CLK_DIV (35 for defaults); busy falls CLK_DIV cycles after done.
- mosi is stable for a full sclk period around each rising edge. mosi holds the last bit after the transfer and returns to 0 in IDLE.
- Half-period counter width is clog2(CLK_DIV)+1. Bit counter width is clog2(word_size)+1. There is no wrap within a transfer.
- A start asserted in the same cycle busy falls is accepted the following cycle. The minimum start-to-start spacing is done time plus CLK_DIV.

Decomposition:
- Shared spi_defs package/include: state encoding (IDLE, SETUP, SCK_HI, SCK_LO, GAP), CPOL=0/CPHA=0 mode constants, and the clog2 helper.
- Sub-module spi_clk_gen: half-period counter with enable and restart. It emits a tick every CLK_DIV cycles and is consumed by the FSM.
- The FSM and shift registers stay in spi_master.

Test Plan:
- Loopback mosi->miso, CLK_DIV=2, send 0xA5 -> data_rcv=0xA5 at cycle 35; exactly 8 sclk rising edges; mosi bits 1,0,1,0,0,1,0,1 sampled at the rising edges.
- miso tied 1, send 0x00 -> data_rcv=0xFF; mosi=0 throughout; done is a single-cycle pulse; cs low for exactly 34 cycles.
- start pulsed again at cycle 10 of a transfer with data 0x3C -> ignored; only one done; data_rcv reflects the first transfer.
- rst asserted at cycle 12 mid-transfer -> next cycle cs=1, sclk=0, busy=0, data_rcv=0; no done pulse; a new start afterwards completes normally.
- CLK_DIV=1, start held high continuously, send 0x81 then 0x7E in loopback -> two transfers, each with done, data_rcv 0x81 then 0x7E; cs high for >=1 cycle between frames.
- word_size=16, CLK_DIV=3, loopback 0xBEEF -> data_rcv=0xBEEF; done at cycle 1+3+96=100.
